// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (d = a - b - bin), LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               brw;
    logic               fs_d;
    logic               fs_bout;
    logic               last_bit;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    brw    <= fs_bout;
                    res_sh <= {fs_d, res_sh[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        d    <= {fs_d, res_sh[WIDTH-1:1]};
                        bout <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the shift registers hold the operand MSBs.
                        ovf  <= (a_sh[0] != b_sh[0]) && (fs_d != a_sh[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int passes = 0;
    int total  = 0;
    logic [W-1:0] last_d = '0;
    logic         last_b = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Full operation: drive start for one cycle, then follow the busy/done timeline.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input bit disturb);
        int           diff;
        logic [W-1:0] exp_d;
        logic         exp_b;
        diff  = int'(av) - int'(bv) - int'(bi);
        exp_d = W'(diff);
        exp_b = (diff < 0);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
            check($sformatf("done_run%0d", i), 32'(done), 32'd0);
            check($sformatf("d_hold_run%0d", i), 32'(d), 32'(last_d));
            check($sformatf("bout_hold_run%0d", i), 32'(bout), 32'(last_b));
            if (disturb) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check($sformatf("d_%0h_%0h_%0h", av, bv, bi), 32'(d), 32'(exp_d));
        check($sformatf("bout_%0h_%0h_%0h", av, bv, bi), 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
        check($sformatf("ovf_%0h_%0h_%0h", av, bv, bi), 32'(ovf),
              32'((av[W-1] != bv[W-1]) && (exp_d[W-1] != av[W-1])));
`endif
        @(negedge clk);
        check("done_low_after", 32'(done), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
        check("d_held_after", 32'(d), 32'(exp_d));
        last_d = exp_d;
        last_b = exp_b;
    endtask

    initial begin
        int t_first;
        int t_second;
        int cyc;

        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed cases
        run_op(4'd9, 4'd3, 1'b0, 1'b0);
        run_op(4'd3, 4'd9, 1'b0, 1'b0);
        run_op(4'd0, 4'd0, 1'b1, 1'b0);
        run_op(4'd5, 4'd5, 1'b0, 1'b0);
        run_op(4'd8, 4'd1, 1'b0, 1'b0);
        run_op(4'd7, 4'd1, 1'b0, 1'b0);
        run_op(4'hF, 4'h0, 1'b1, 1'b0);

        // Inputs and start toggled while running
        run_op(4'd12, 4'd5, 1'b1, 1'b1);
        run_op(4'd2, 4'd14, 1'b0, 1'b1);

        // Random operands
        for (int k = 0; k < 16; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        // Start held high: done pulses spaced WIDTH+2 cycles apart
        @(negedge clk);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        t_first = -1; t_second = -1; cyc = 0;
        while (cyc < 40 && t_second < 0) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t_first < 0) t_first = cyc;
                else t_second = cyc;
            end
        end
        start = 1'b0;
        check("held_first_done_seen", 32'(t_first >= 0), 32'd1);
        check("held_second_done_seen", 32'(t_second >= 0), 32'd1);
        check("held_spacing", 32'(t_second - t_first), 32'(W + 2));
        check("held_d", 32'(d), 32'd6);
        repeat (W + 3) @(negedge clk);
        check("held_settled_busy", 32'(busy), 32'd0);
        last_d = 4'd6;
        last_b = 1'b0;

        // Reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a = 4'd3; b = 4'd9; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_d", 32'(d), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int saw_done;
            saw_done = 0;
            for (int i = 0; i < W + 3; i++) begin
                @(negedge clk);
                if (done || busy) saw_done = 1;
            end
            check("no_done_after_abort", 32'(saw_done), 32'd0);
        end
        last_d = '0;
        last_b = 1'b0;
        run_op(4'd9, 4'd3, 1'b0, 1'b0);
        run_op(4'd1, 4'd2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing d = a − b − bin, one bit per clock, LSB first, with start/busy/done handshake. It is the inverse-operation counterpart to the team's ripple-carry adder. It trades the parallel borrow chain for a single full-subtractor cell plus shift registers. It sits beside the adder in the datapath wherever area matters more than latency.

## Interface

- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse, result valid
- d  output  WIDTH  difference, registered, held until next completion
- bout  output  1  borrow-out, registered, held like d
- ovf  output  1  signed overflow, only when SERIAL_SUB_OVF_EN defined

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b, bin into shift regs/borrow flop; cnt=0; go RUN. start=0 → stay.
- RUN: each cycle, full_subtractor takes a_sh[0], b_sh[0], borrow flop. Diff bit shifts into the MSB of the result shift reg. The new borrow is registered. a_sh/b_sh shift right; cnt++. When cnt==WIDTH−1, load d/bout (and ovf) from the final values and go DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored (no queuing). a/b/bin changes after capture have no effect.
- Arithmetic: d = (a − b − bin) mod 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- d/bout change only on the RUN→DONE edge, never mid-operation.
- Reset (any time, including mid-RUN): state IDLE; busy, done, d, bout, ovf, cnt, and all shift regs = 0. Operation aborted, no done pulse.

## Timing

- Start sampled high in IDLE at edge N. busy=1 for cycles N+1 … N+WIDTH. d/bout update and done=1 in cycle N+WIDTH+1. Back in IDLE at cycle N+WIDTH+2.
- Latency start→done: WIDTH+1 cycles. Max throughput: one operation per WIDTH+2 cycles (start may be held high continuously).
- busy and done are never high simultaneously. Both are registered state decodes with no combinational path from inputs.

## Configuration

- SERIAL_SUB_OVF_EN defined: port ovf exists. ovf = (a[MSB]≠b[MSB]) && (d[MSB]≠a[MSB]), two's-complement view, bin treated as part of b. It is loaded with d and reset to 0.
- Undefined: no ovf port and no MSB-capture logic. All other behaviour is identical.

## Structure

- Package serial_sub_pkg: state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
- Sub-module full_subtractor (a, b, bin → d, bout; d = a^b^bin, bout = (~a&b) | (~(a^b)&bin)). It is instantiated once; it is purely combinational.
- Counter width: $clog2(WIDTH).

## Test plan

- a=9, b=3, bin=0, start pulse → busy cycles 1–4, done cycle 5, d=6, bout=0.
- a=3, b=9, bin=0 → d=4'hA, bout=1.
- a=0, b=0, bin=1 → d=4'hF, bout=1. Also a=5, b=5, bin=0 → d=0, bout=0.
- With SERIAL_SUB_OVF_EN: a=8, b=1 → d=7, ovf=1. a=7, b=1 → d=6, ovf=0.
- start toggled and a/b changed during RUN → ignored; result matches captured operands; exactly one done pulse. Start held high → new operation every 6 cycles.
- rst_n low in RUN cycle 2 → all outputs 0 immediately, no done. A fresh start after release completes normally.
